read_channel_axi: RTL and testbench

Backend line-fill reader for the AXI cache. It receives a line-replacement request from the cache controller and issues one INCR AXI read burst for the whole cache line. It streams each returned beat to the data memory with its word index, then releases the controller. It is the read-side counterpart of the cache's AXI write channel and shares that channel's AXI parameter set.

---
 rtl/iob_cache_axi_pkg.sv | 23 ++
 rtl/read_channel_axi.sv | 169 ++++++++++++++++
 tb/tb_read_channel_axi.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_cache_axi_pkg.sv
// -----------------------------------------------------------------------------
// iob_cache_axi_pkg
// Shared definitions for the AXI cache backend channels (read and write).
//   state_t          : channel FSM states (IDLE / ADDR / DATA)
//   AXI_BURST_INCR   : INCR burst encoding
//   AXI_RESP_OKAY    : OKAY response encoding
//   AXI_LOCK_NORMAL, AXI_PROT_DEFAULT, AXI_QOS_DEFAULT : constant AX fields
// -----------------------------------------------------------------------------
package iob_cache_axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic       AXI_LOCK_NORMAL  = 1'b0;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
    localparam logic [3:0] AXI_QOS_DEFAULT  = 4'b0000;

endpackage

// File: rtl/read_channel_axi.sv
// -----------------------------------------------------------------------------
// read_channel_axi
// Line-fill reader for the AXI cache: one INCR read burst per replaced line,
// each returned beat forwarded to the data memory with its beat index.
//
// Ports:
//   ap_clk, reset        : clock, synchronous active-high reset
//   replace_valid/addr   : line-fill request and line address
//   replace              : busy while a fill is in progress
//   read_valid/addr/rdata: beat write port towards the data memory
//   m_axi_ar* / m_axi_r* : AXI4 read-address and read-data channels
//
// Build option: CACHE_AXI_READ_RETRY_EN re-issues a whole burst that saw a
// non-OKAY response or an early rlast. Undefined: rresp is ignored.
// -----------------------------------------------------------------------------
module read_channel_axi
    import iob_cache_axi_pkg::*;
#(
    parameter int          CACHE_FRONTEND_ADDR_W = 32,
    parameter int          CACHE_FRONTEND_DATA_W = 32,
    parameter int          CACHE_BACKEND_ADDR_W  = CACHE_FRONTEND_ADDR_W,
    parameter int          CACHE_BACKEND_DATA_W  = CACHE_FRONTEND_DATA_W,
    parameter int          CACHE_WORD_OFF_W      = 3,
    parameter int          CACHE_AXI_LEN_W       = 8,
    parameter int          CACHE_AXI_ID_W        = 1,
    parameter int          CACHE_AXI_ID          = 0,
    parameter logic [3:0]  CACHE_AXI_CACHE_MODE  = 4'b0011,
    localparam int BE_BYTE_W = $clog2(CACHE_BACKEND_DATA_W / 8),
    localparam int LINE2BE_W = CACHE_WORD_OFF_W
                               - $clog2(CACHE_BACKEND_DATA_W / CACHE_FRONTEND_DATA_W),
    localparam int BEATS     = 2 ** LINE2BE_W,
    localparam int CNT_W     = (LINE2BE_W > 0) ? LINE2BE_W : 1,
    localparam int OFF_W     = BE_BYTE_W + LINE2BE_W
) (
    input  logic                                       ap_clk,
    input  logic                                       reset,

    input  logic                                       replace_valid,
    input  logic [CACHE_FRONTEND_ADDR_W-1:OFF_W]       replace_addr,
    output logic                                       replace,

    output logic                                       read_valid,
    output logic [CNT_W-1:0]                           read_addr,
    output logic [CACHE_BACKEND_DATA_W-1:0]            read_rdata,

    output logic [CACHE_AXI_ID_W-1:0]                  m_axi_arid,
    output logic [CACHE_BACKEND_ADDR_W-1:0]            m_axi_araddr,
    output logic [CACHE_AXI_LEN_W-1:0]                 m_axi_arlen,
    output logic [2:0]                                 m_axi_arsize,
    output logic [1:0]                                 m_axi_arburst,
    output logic                                       m_axi_arlock,
    output logic [3:0]                                 m_axi_arcache,
    output logic [2:0]                                 m_axi_arprot,
    output logic [3:0]                                 m_axi_arqos,
    output logic                                       m_axi_arvalid,
    input  logic                                       m_axi_arready,

    input  logic [CACHE_AXI_ID_W-1:0]                  m_axi_rid,
    input  logic [CACHE_BACKEND_DATA_W-1:0]            m_axi_rdata,
    input  logic [1:0]                                 m_axi_rresp,
    input  logic                                       m_axi_rlast,
    input  logic                                       m_axi_rvalid,
    output logic                                       m_axi_rready
);

    state_t                                state_q, state_d;
    logic [CNT_W-1:0]                      cnt;
    logic [CACHE_FRONTEND_ADDR_W-1:OFF_W]  addr_q;
    logic                                  beat_ok;
    logic                                  cnt_last;
    logic                                  retry;

    // Constant read-address fields
    assign m_axi_arid    = CACHE_AXI_ID_W'(CACHE_AXI_ID);
    assign m_axi_araddr  = CACHE_BACKEND_ADDR_W'({addr_q, OFF_W'(0)});
    assign m_axi_arlen   = CACHE_AXI_LEN_W'(BEATS - 1);
    assign m_axi_arsize  = 3'(BE_BYTE_W);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = AXI_LOCK_NORMAL;
    assign m_axi_arcache = CACHE_AXI_CACHE_MODE;
    assign m_axi_arprot  = AXI_PROT_DEFAULT;
    assign m_axi_arqos   = AXI_QOS_DEFAULT;

    // rready is high throughout DATA, so a beat is accepted whenever rvalid is
    assign beat_ok    = (state_q == DATA) && m_axi_rvalid;
    assign cnt_last   = (cnt == CNT_W'(BEATS - 1));

    // Outputs are gated by reset so nothing is written while it is held
    assign read_valid = beat_ok && !reset;
    assign read_addr  = cnt;
    assign read_rdata = m_axi_rdata;

`ifdef CACHE_AXI_READ_RETRY_EN
    logic err_q;
    logic beat_err;
    logic unused_in;

    assign beat_err  = (m_axi_rresp != AXI_RESP_OKAY);
    // An rlast before the final beat index is treated as a failed burst too
    assign retry     = err_q || beat_err || !cnt_last;
    assign unused_in = ^m_axi_rid;

    // Cleared at the end of every burst so a retried burst is judged on its own
    always_ff @(posedge ap_clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && replace_valid) begin
            err_q <= 1'b0;
        end else if (beat_ok) begin
            err_q <= m_axi_rlast ? 1'b0 : (err_q || beat_err);
        end
    end
`else
    logic unused_in;

    assign retry     = 1'b0;
    assign unused_in = ^{m_axi_rid, m_axi_rresp, cnt_last};
`endif

    always_comb begin
        state_d       = state_q;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        replace       = 1'b0;
        case (state_q)
            IDLE: begin
                if (replace_valid) state_d = ADDR;
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                replace       = 1'b1;
                if (m_axi_arready) state_d = DATA;
            end
            DATA: begin
                m_axi_rready = 1'b1;
                replace      = 1'b1;
                if (beat_ok && m_axi_rlast) state_d = retry ? ADDR : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            m_axi_arvalid = 1'b0;
            m_axi_rready  = 1'b0;
            replace       = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ADDR && m_axi_arready) begin
                cnt <= '0;
            end else if (beat_ok) begin
                // Single-beat lines keep the index pinned at 0
                cnt <= (BEATS == 1) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (state_q == IDLE && replace_valid && !reset) begin
            addr_q <= replace_addr;
        end
    end

endmodule

// File: tb/tb_read_channel_axi.sv
// -----------------------------------------------------------------------------
// tb_read_channel_axi
// Scoreboard bench for read_channel_axi: stimulus pushes expected AR requests
// and beat writes into queues; a negedge monitor pops and compares them.
// A second instance uses a 256-bit backend (single-beat lines).
// -----------------------------------------------------------------------------
module tb_read_channel_axi;

    logic ap_clk = 1'b0;
    logic reset;
    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- default instance ----------------
    logic         replace_valid;
    logic [31:5]  replace_addr;
    logic         replace;
    logic         read_valid;
    logic [2:0]   read_addr;
    logic [31:0]  read_rdata;
    logic [0:0]   m_axi_arid;
    logic [31:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arlock;
    logic [3:0]   m_axi_arcache;
    logic [2:0]   m_axi_arprot;
    logic [3:0]   m_axi_arqos;
    logic         m_axi_arvalid;
    logic         m_axi_arready;
    logic [0:0]   m_axi_rid;
    logic [31:0]  m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic         m_axi_rvalid;
    logic         m_axi_rready;

    read_channel_axi dut (
        .ap_clk(ap_clk), .reset(reset),
        .replace_valid(replace_valid), .replace_addr(replace_addr), .replace(replace),
        .read_valid(read_valid), .read_addr(read_addr), .read_rdata(read_rdata),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // ---------------- 256-bit backend instance ----------------
    logic         w_replace_valid;
    logic [31:5]  w_replace_addr;
    logic         w_replace;
    logic         w_read_valid;
    logic [0:0]   w_read_addr;
    logic [255:0] w_read_rdata;
    logic [0:0]   w_arid;
    logic [31:0]  w_araddr;
    logic [7:0]   w_arlen;
    logic [2:0]   w_arsize;
    logic [1:0]   w_arburst;
    logic         w_arlock;
    logic [3:0]   w_arcache;
    logic [2:0]   w_arprot;
    logic [3:0]   w_arqos;
    logic         w_arvalid;
    logic         w_arready;
    logic [0:0]   w_rid;
    logic [255:0] w_rdata;
    logic [1:0]   w_rresp;
    logic         w_rlast;
    logic         w_rvalid;
    logic         w_rready;

    read_channel_axi #(.CACHE_BACKEND_DATA_W(256)) dut_w (
        .ap_clk(ap_clk), .reset(reset),
        .replace_valid(w_replace_valid), .replace_addr(w_replace_addr), .replace(w_replace),
        .read_valid(w_read_valid), .read_addr(w_read_addr), .read_rdata(w_read_rdata),
        .m_axi_arid(w_arid), .m_axi_araddr(w_araddr), .m_axi_arlen(w_arlen),
        .m_axi_arsize(w_arsize), .m_axi_arburst(w_arburst), .m_axi_arlock(w_arlock),
        .m_axi_arcache(w_arcache), .m_axi_arprot(w_arprot), .m_axi_arqos(w_arqos),
        .m_axi_arvalid(w_arvalid), .m_axi_arready(w_arready),
        .m_axi_rid(w_rid), .m_axi_rdata(w_rdata), .m_axi_rresp(w_rresp),
        .m_axi_rlast(w_rlast), .m_axi_rvalid(w_rvalid), .m_axi_rready(w_rready)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [2:0]   idx;
        logic [255:0] data;
    } beat_t;

    beat_t       beat_q[$];
    beat_t       w_beat_q[$];
    logic [31:0] ar_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic missing(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual output with empty queue required none", name);
    endtask

    always @(negedge ap_clk) begin : monitor
        beat_t       e;
        logic [31:0] a;
        if (read_valid === 1'b1) begin
            if (beat_q.size() == 0) missing("read_valid");
            else begin
                e = beat_q.pop_front();
                check("read_addr", 256'(read_addr), 256'(e.idx));
                check("read_rdata", 256'(read_rdata), e.data);
            end
        end
        if (m_axi_arvalid === 1'b1 && m_axi_arready === 1'b1) begin
            if (ar_q.size() == 0) missing("ar_handshake");
            else begin
                a = ar_q.pop_front();
                check("araddr", 256'(m_axi_araddr), 256'(a));
                check("arlen", 256'(m_axi_arlen), 256'(7));
                check("arsize", 256'(m_axi_arsize), 256'(2));
                check("arburst", 256'(m_axi_arburst), 256'(1));
                check("arcache", 256'(m_axi_arcache), 256'(3));
                check("arid", 256'(m_axi_arid), 256'(0));
            end
        end
        if (w_read_valid === 1'b1) begin
            if (w_beat_q.size() == 0) missing("w_read_valid");
            else begin
                e = w_beat_q.pop_front();
                check("w_read_addr", 256'(w_read_addr), 256'(e.idx));
                check("w_read_rdata", w_read_rdata, e.data);
            end
        end
    end

    // ---------------- stimulus ----------------
    int data_seed = 0;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Called with the DUT in ADDR; holds arready low for wait_n cycles
    task automatic ar_phase(input logic [31:0] exp_addr, input int wait_n);
        check("arvalid_up", 256'(m_axi_arvalid), 256'(1));
        check("replace_up", 256'(replace), 256'(1));
        ar_q.push_back(exp_addr);
        for (int i = 0; i < wait_n; i++) begin
            check("araddr_hold", 256'(m_axi_araddr), 256'(exp_addr));
            check("rready_wait", 256'(m_axi_rready), 256'(0));
            tick();
            check("arvalid_hold", 256'(m_axi_arvalid), 256'(1));
        end
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        check("rready_after_ar", 256'(m_axi_rready), 256'(1));
    endtask

    // Slot s carries a beat when mask[s%16]; rlast on beat nbeats-1
    task automatic r_phase(input logic [15:0] mask, input int nbeats, input int err_beat);
        int b = 0;
        int s = 0;
        logic v;
        while (b < nbeats && s < 200) begin
            v = mask[s % 16];
            m_axi_rvalid = v;
            m_axi_rdata  = 32'hA500_0000 + 32'(data_seed * 16 + b);
            m_axi_rresp  = (v && b == err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast  = v && (b == nbeats - 1);
            if (v) beat_q.push_back('{idx: 3'(b), data: 256'(m_axi_rdata)});
            #1;
            check("read_valid_mirror", 256'(read_valid), 256'(v));
            tick();
            if (v) b++;
            s++;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        data_seed++;
    endtask

    task automatic fill(input logic [26:0] a, input int ar_wait, input logic [15:0] mask,
                        input int nbeats, input int err_beat);
        replace_valid = 1'b1;
        replace_addr  = a;
        tick();
        replace_valid = 1'b0;
        ar_phase({a, 5'b0}, ar_wait);
        r_phase(mask, nbeats, err_beat);
`ifdef CACHE_AXI_READ_RETRY_EN
        if (err_beat >= 0 || nbeats != 8) begin
            ar_phase({a, 5'b0}, 0);
            r_phase(16'hFFFF, 8, -1);
        end
`endif
        check("replace_fall", 256'(replace), 256'(0));
        check("arvalid_idle", 256'(m_axi_arvalid), 256'(0));
        check("rready_idle", 256'(m_axi_rready), 256'(0));
    endtask

    initial begin
        reset = 1'b1;
        replace_valid = 1'b0; replace_addr = '0;
        m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
        w_replace_valid = 1'b0; w_replace_addr = '0;
        w_arready = 1'b0; w_rid = '0; w_rdata = '0;
        w_rresp = 2'b00; w_rlast = 1'b0; w_rvalid = 1'b0;

        tick();
        tick();
        m_axi_rvalid = 1'b1;
        #1;
        check("rst_read_valid", 256'(read_valid), 256'(0));
        check("rst_arvalid", 256'(m_axi_arvalid), 256'(0));
        check("rst_rready", 256'(m_axi_rready), 256'(0));
        check("rst_replace", 256'(replace), 256'(0));
        m_axi_rvalid = 1'b0;
        reset = 1'b0;
        tick();
        check("idle_replace", 256'(replace), 256'(0));

        // Zero-wait fill at 0x82 -> araddr 0x1040, followed back-to-back by another
        fill(27'h82, 0, 16'hFFFF, 8, -1);
        fill(27'h7, 0, 16'hFFFF, 8, -1);
        // arready held off for 5 cycles
        fill(27'h1234, 5, 16'hFFFF, 8, -1);
        // rvalid pattern 1,0,0,1,...
        fill(27'h55, 1, 16'h9999, 8, -1);
        // SLVERR on beat 3
        fill(27'h3FF, 0, 16'hFFFF, 8, 3);
        // Early rlast after 5 beats
        fill(27'h40, 0, 16'hFFFF, 5, -1);

        // Reset on beat 4 of a burst
        replace_valid = 1'b1;
        replace_addr  = 27'h99;
        tick();
        replace_valid = 1'b0;
        ar_phase({27'h99, 5'b0}, 0);
        for (int b = 0; b < 4; b++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 32'hC0DE_0000 + 32'(b);
            beat_q.push_back('{idx: 3'(b), data: 256'(m_axi_rdata)});
            tick();
        end
        reset = 1'b1;
        m_axi_rdata = 32'hDEAD_BEEF;
        #1;
        check("rst_mid_read_valid", 256'(read_valid), 256'(0));
        check("rst_mid_replace", 256'(replace), 256'(0));
        tick();
        reset = 1'b0;
        m_axi_rvalid = 1'b0;
        check("post_rst_replace", 256'(replace), 256'(0));
        check("post_rst_rready", 256'(m_axi_rready), 256'(0));
        check("post_rst_arvalid", 256'(m_axi_arvalid), 256'(0));
        fill(27'h21, 0, 16'hFFFF, 8, -1);

        // 256-bit backend: one beat per line
        w_replace_valid = 1'b1;
        w_replace_addr  = 27'h3;
        tick();
        w_replace_valid = 1'b0;
        check("w_arvalid", 256'(w_arvalid), 256'(1));
        check("w_replace_1", 256'(w_replace), 256'(1));
        check("w_araddr", 256'(w_araddr), 256'(32'h60));
        check("w_arlen", 256'(w_arlen), 256'(0));
        check("w_arsize", 256'(w_arsize), 256'(5));
        w_arready = 1'b1;
        tick();
        w_arready = 1'b0;
        check("w_rready", 256'(w_rready), 256'(1));
        check("w_replace_2", 256'(w_replace), 256'(1));
        w_rvalid = 1'b1;
        w_rlast  = 1'b1;
        w_rdata  = {8{32'h1357_9BDF}};
        w_beat_q.push_back('{idx: 3'd0, data: w_rdata});
        tick();
        w_rvalid = 1'b0;
        w_rlast  = 1'b0;
        check("w_replace_fall", 256'(w_replace), 256'(0));

        tick();
        tick();
        check("ar_q_drained", 256'(ar_q.size()), 256'(0));
        check("beat_q_drained", 256'(beat_q.size()), 256'(0));
        check("w_beat_q_drained", 256'(w_beat_q.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: actual time limit reached required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
